// File: rtl/piso_serializer.sv
// Framed parallel-in/serial-out serializer: start bit, WIDTH data bits LSB-first,
// stop bit, each held for DIV clocks, with a strobe on every bit boundary.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             O,
  output logic             BUSY,
  output logic             BIT_STB
);
  localparam int DW = (DIV   > 1) ? $clog2(DIV)   : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t           state, state_n;
  logic [DW-1:0]    div_cnt, div_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic             o_n, busy_n, stb_n;
  logic             div_wrap, accept;

  assign div_wrap = (div_cnt == DW'(DIV - 1));
  // Only idle or the very last stop cycle can take a word; reset masks it.
  assign READY    = RESETN && ((state == IDLE) || ((state == STOP) && div_wrap));
  assign accept   = VALID && READY;

  // Next-state logic; outputs are derived from the next state so the
  // registered O/BUSY/BIT_STB line up with the state they describe.
  always_comb begin
    state_n = state;
    div_n   = div_wrap ? '0 : div_cnt + 1'b1;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    case (state)
      IDLE: begin
        div_n = '0;
        if (accept) begin
          shreg_n = DATA;
          state_n = START;
        end
      end
      START: begin
        if (div_wrap) begin
          state_n = SHIFT;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        if (div_wrap) begin
          shreg_n = shreg >> 1;
          bit_n   = bit_cnt + 1'b1;
          if (bit_cnt == BW'(WIDTH - 1)) state_n = STOP;
        end
      end
      STOP: begin
        if (div_wrap) begin
          if (accept) begin
            // back-to-back: next start bit follows the stop bit directly
            shreg_n = DATA;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    o_n    = (state_n == START) ? 1'b0 :
             (state_n == SHIFT) ? shreg_n[0] : 1'b1;
    busy_n = (state_n != IDLE);
    stb_n  = busy_n && (div_n == '0);
  end

  // State, counters, data and registered outputs; reset aborts any frame.
  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state   <= IDLE;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      O       <= 1'b1;
      BUSY    <= 1'b0;
      BIT_STB <= 1'b0;
    end else begin
      state   <= state_n;
      div_cnt <= div_n;
      bit_cnt <= bit_n;
      shreg   <= shreg_n;
      O       <= o_n;
      BUSY    <= busy_n;
      BIT_STB <= stb_n;
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// Randomized + directed bench: two serializers (DIV=4, DIV=1) share stimulus and
// are compared each cycle against a frame-level model.
module tb_piso_serializer;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [W-1:0] data;
  logic         valid;
  logic [1:0]   ready, o, busy, stb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W), .DIV(4)) dut4 (
    .CLK(clk), .RESETN(rstn), .DATA(data), .VALID(valid),
    .READY(ready[0]), .O(o[0]), .BUSY(busy[0]), .BIT_STB(stb[0]));

  piso_serializer #(.WIDTH(W), .DIV(1)) dut1 (
    .CLK(clk), .RESETN(rstn), .DATA(data), .VALID(valid),
    .READY(ready[1]), .O(o[1]), .BUSY(busy[1]), .BIT_STB(stb[1]));

  // Model: a frame is a (W+2)-bit pattern {stop, data, start}; k is the clock
  // index within the frame, so bit = k/div and strobe = (k%div == 0).
  int           divs [2] = '{4, 1};
  bit           act  [2];
  int           k    [2];
  logic [W+1:0] fb   [2];

  function automatic bit exp_ready(int i);
    return rstn && (!act[i] || k[i] == (W + 2) * divs[i] - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h, want %0h", tag, $time, got, exp);
    end
  endtask

  // One clock: check READY, advance model at the edge, check registered outputs.
  task automatic cycle();
    bit acc [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready%0d", i), 32'(ready[i]), 32'(exp_ready(i)));
      acc[i] = valid && exp_ready(i);
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rstn) begin
        act[i] = 1'b0;
      end else if (acc[i]) begin
        act[i] = 1'b1;
        k[i]   = 0;
        fb[i]  = {1'b1, data, 1'b0};
      end else if (act[i]) begin
        k[i]++;
        if (k[i] == (W + 2) * divs[i]) act[i] = 1'b0;
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("o%0d", i),    32'(o[i]),    32'(act[i] ? fb[i][k[i] / divs[i]] : 1'b1));
      chk($sformatf("busy%0d", i), 32'(busy[i]), 32'(act[i]));
      chk($sformatf("stb%0d", i),  32'(stb[i]),  32'(act[i] && (k[i] % divs[i] == 0)));
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) cycle();
  endtask

  task automatic send(input logic [W-1:0] d, input int idle);
    valid = 1'b1; data = d;
    cycle();
    valid = 1'b0;
    run(idle);
  endtask

  // Directed scenarios first, then random traffic with occasional resets.
  initial begin
    act = '{0, 0}; k = '{0, 0}; fb = '{0, 0};
    rstn = 1'b0; valid = 1'b0; data = '0;
    @(negedge clk);
    run(3);                           // reset held: READY=0, O=1, idle
    rstn = 1'b1;
    run(2);                           // READY=1 once released
    send(8'hA5, 45);                  // single frame
    valid = 1'b1; data = 8'h00;       // back-to-back 0x00 then 0xFF
    cycle();
    data = 8'hFF;
    run(40);
    valid = 1'b0;
    run(50);
    valid = 1'b1; data = 8'hA5;       // mid-frame VALID/DATA ignored
    cycle();
    data = 8'h3C;
    run(45);
    valid = 1'b0;
    run(50);
    send(8'hA5, 18);                  // reset during data bit 3
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    run(2);
    send(8'h5A, 45);
    send(8'h81, 45);                  // DIV=1 instance: 0,1,0,0,0,0,0,0,1,1
    for (int c = 0; c < 3000; c++) begin
      rstn  = ($urandom_range(199) != 0);
      valid = ($urandom_range(3) != 0);
      data  = W'($urandom);
      cycle();
    end
    rstn = 1'b1; valid = 1'b0;
    run(45);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
